// File: rtl/stack_address_sequencer.sv
// Address sequencer for an activation stack. Each pass writes LAYER_MAX+1 activations in forward
// order, then issues paired-read addresses in reverse order for the backward pass.
module stack_address_sequencer #(
  parameter int unsigned LAYER_MAX        = 3,
  parameter int unsigned STACK_ADDR_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_valid,
  output logic                          start_ready,
  input  logic [STACK_ADDR_WIDTH-1:0]   start_base,
  output logic [STACK_ADDR_WIDTH-1:0]   wr_addr,
  output logic                          wr_addr_valid,
  input  logic                          wr_addr_ready,
  input  logic                          bwd_go,
  output logic [STACK_ADDR_WIDTH-1:0]   rd_addr,
  output logic                          rd_addr_valid,
  input  logic                          rd_addr_ready,
  output logic [$clog2(LAYER_MAX):0]    rd_layer,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned W      = STACK_ADDR_WIDTH;
  localparam int unsigned LayerW = $clog2(LAYER_MAX) + 1;

  localparam logic [W-1:0] LastWr  = W'(LAYER_MAX);
  localparam logic [W-1:0] FirstRd = W'(LAYER_MAX - 1);
  localparam logic [W-1:0] One     = W'(1);

  typedef enum logic [1:0] {StIdle, StWrite, StWaitBwd, StRead} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] base_q, base_d;
  logic [W-1:0] wr_cnt_q, wr_cnt_d;
  logic [W-1:0] rd_cnt_q, rd_cnt_d;
  logic         done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      base_q   <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          base_d   = start_base;
          wr_cnt_d = '0;
          state_d  = StWrite;
        end
      end
      StWrite: begin
        if (wr_addr_ready) begin
          if (wr_cnt_q == LastWr) begin
            rd_cnt_d = FirstRd;
            state_d  = bwd_go ? StRead : StWaitBwd;
          end else begin
            wr_cnt_d = wr_cnt_q + One;
          end
        end
      end
      StWaitBwd: begin
        if (bwd_go) begin
          rd_cnt_d = FirstRd;
          state_d  = StRead;
        end
      end
      StRead: begin
        if (bwd_go && rd_addr_ready) begin
          if (rd_cnt_q == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            rd_cnt_d = rd_cnt_q - One;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort wins over any handshake in the same cycle; the beat is dropped.
    if (abort && (state_q != StIdle)) begin
      state_d  = StIdle;
      base_d   = base_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      done_d   = 1'b0;
    end
  end

  always_comb begin
    start_ready   = (state_q == StIdle);
    busy          = (state_q != StIdle);
    done          = done_q;
    wr_addr_valid = (state_q == StWrite);
    wr_addr       = (state_q == StWrite) ? (base_q + wr_cnt_q) : '0;
    // Read valid follows bwd_go combinationally so the backward pass can pause instantly.
    rd_addr_valid = (state_q == StRead) && bwd_go;
    rd_addr       = (state_q == StRead) ? (base_q + rd_cnt_q) : '0;
    rd_layer      = (state_q == StRead) ? LayerW'(rd_cnt_q) : '0;
  end

endmodule

// File: tb/tb_stack_address_sequencer.sv
// Randomized bench for stack_address_sequencer: queue-based model of expected write/read order,
// plus directed abort, reset and LAYER_MAX=1 scenarios.
module tb_stack_address_sequencer;

  localparam int L = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_valid, start_ready;
  logic [9:0] start_base;
  logic [9:0] wr_addr, rd_addr;
  logic       wr_addr_valid, wr_addr_ready;
  logic       rd_addr_valid, rd_addr_ready;
  logic       bwd_go, abort, busy, done;
  logic [2:0] rd_layer;

  logic       d1_start_valid, d1_start_ready;
  logic [9:0] d1_start_base, d1_wr_addr, d1_rd_addr;
  logic       d1_wr_valid, d1_rd_valid, d1_busy, d1_done;
  logic [0:0] d1_rd_layer;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stack_address_sequencer #(.LAYER_MAX(L), .STACK_ADDR_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready), .start_base(start_base),
    .wr_addr(wr_addr), .wr_addr_valid(wr_addr_valid), .wr_addr_ready(wr_addr_ready),
    .bwd_go(bwd_go),
    .rd_addr(rd_addr), .rd_addr_valid(rd_addr_valid), .rd_addr_ready(rd_addr_ready),
    .rd_layer(rd_layer), .abort(abort), .busy(busy), .done(done)
  );

  stack_address_sequencer #(.LAYER_MAX(1), .STACK_ADDR_WIDTH(10)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(d1_start_valid), .start_ready(d1_start_ready), .start_base(d1_start_base),
    .wr_addr(d1_wr_addr), .wr_addr_valid(d1_wr_valid), .wr_addr_ready(1'b1),
    .bwd_go(1'b1),
    .rd_addr(d1_rd_addr), .rd_addr_valid(d1_rd_valid), .rd_addr_ready(1'b1),
    .rd_layer(d1_rd_layer), .abort(1'b0), .busy(d1_busy), .done(d1_done)
  );

  task automatic test_reset();
    rst_n = 1'b0; start_valid = 0; start_base = 0; wr_addr_ready = 0; rd_addr_ready = 0;
    bwd_go = 0; abort = 0; d1_start_valid = 0; d1_start_base = 0;
    #12;
    n_checks++;
    if ({wr_addr_valid, rd_addr_valid, busy, done, wr_addr, rd_addr, rd_layer} !== 27'd0) begin
      n_errors++;
      $display("FAIL reset_outputs got wv=%b rv=%b busy=%b done=%b wa=%0d ra=%0d rl=%0d exp all 0",
               wr_addr_valid, rd_addr_valid, busy, done, wr_addr, rd_addr, rd_layer);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++;
    if (start_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_start_ready got %b exp 1", start_ready);
    end
  endtask

  // mode 0: bwd_go held 1; mode 1: bwd_go random; mode 2: bwd_go low until 10 cycles after writes
  task automatic run_pass(input logic [9:0] b, input int stall, input int mode, input string tag);
    logic [9:0] wq[$];
    logic [9:0] rq[$];
    int lq[$];
    int wi = 0, ri = 0, cyc = 0, hold = 0, done_cyc = -1;
    bit fin = 0;
    for (int i = 0; i <= L; i++) wq.push_back(b + 10'(i));
    for (int j = L - 1; j >= 0; j--) begin rq.push_back(b + 10'(j)); lq.push_back(j); end
    @(negedge clk); start_valid = 1; start_base = b; #1;
    n_checks++;
    if (start_ready !== 1'b1) begin
      n_errors++; $display("FAIL %s start_ready got %b exp 1", tag, start_ready);
    end
    @(negedge clk); start_valid = 0;
    while (!fin && cyc < 2000) begin
      wr_addr_ready = ($urandom_range(99) >= stall);
      rd_addr_ready = ($urandom_range(99) >= stall);
      if (mode == 0) bwd_go = 1;
      else if (mode == 1) bwd_go = 1'($urandom_range(1));
      else if (wi <= L) bwd_go = 0;
      else if (hold < 10) begin bwd_go = 0; hold++; end
      else bwd_go = 1'($urandom_range(1));
      #1;
      if (done === 1'b1) begin
        fin = 1; done_cyc = cyc;
        n_checks++;
        if (wi != L + 1 || ri != L) begin
          n_errors++; $display("FAIL %s beat_count got w=%0d r=%0d exp w=%0d r=%0d",
                               tag, wi, ri, L + 1, L);
        end
      end else begin
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL %s busy got %b exp 1", tag, busy); end
        if (wr_addr_valid === 1'b1) begin
          n_checks++;
          if (!(wi <= L && wr_addr === wq[wi])) begin
            n_errors++; $display("FAIL %s wr_addr beat %0d got %0d exp %0d", tag, wi, wr_addr,
                                 (wi <= L) ? wq[wi] : 10'h3ff);
          end
          if (wr_addr_ready) wi++;
        end
        if (bwd_go == 1'b0 || wi <= L) begin
          n_checks++;
          if (rd_addr_valid !== 1'b0) begin
            n_errors++; $display("FAIL %s rd_valid_gated got %b exp 0", tag, rd_addr_valid);
          end
        end
        if (rd_addr_valid === 1'b1) begin
          n_checks++;
          if (!(ri < L && rd_addr === rq[ri] && rd_layer === 3'(lq[ri]))) begin
            n_errors++; $display("FAIL %s rd beat %0d got addr=%0d layer=%0d exp addr=%0d layer=%0d",
                                 tag, ri, rd_addr, rd_layer, (ri < L) ? rq[ri] : 10'h3ff,
                                 (ri < L) ? lq[ri] : -1);
          end
          if (rd_addr_ready) ri++;
        end
      end
      cyc++;
      if (!fin) @(negedge clk);
    end
    n_checks++;
    if (!fin) begin n_errors++; $display("FAIL %s timeout got no done exp done", tag); end
    if (mode == 0 && stall == 0) begin
      n_checks++;
      if (done_cyc != 2 * L + 1) begin
        n_errors++; $display("FAIL %s latency got %0d exp %0d", tag, done_cyc, 2 * L + 1);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
      n_errors++; $display("FAIL %s post_done got done=%b ready=%b busy=%b exp 0 1 0",
                           tag, done, start_ready, busy);
    end
    wr_addr_ready = 0; rd_addr_ready = 0; bwd_go = 0;
  endtask

  task automatic test_abort();
    @(negedge clk); start_valid = 1; start_base = 10'd100;
    @(negedge clk); start_valid = 0; wr_addr_ready = 1; bwd_go = 1;
    @(negedge clk); abort = 1; #1;
    n_checks++;
    if (wr_addr !== 10'd101) begin
      n_errors++; $display("FAIL abort_pre_addr got %0d exp 101", wr_addr);
    end
    @(negedge clk); abort = 0; wr_addr_ready = 0; #1;
    n_checks++;
    if (busy !== 0 || wr_addr_valid !== 0 || rd_addr_valid !== 0 || start_ready !== 1 || done !== 0)
    begin
      n_errors++; $display("FAIL abort_idle got busy=%b wv=%b rv=%b sr=%b done=%b exp 0 0 0 1 0",
                           busy, wr_addr_valid, rd_addr_valid, start_ready, done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (done !== 1'b0) begin n_errors++; $display("FAIL abort_no_done got %b exp 0", done); end
    end
    bwd_go = 0;
    run_pass(10'd100, 30, 1, "after_abort");
    // abort together with start in IDLE: start wins
    @(negedge clk); start_valid = 1; abort = 1; start_base = 10'd7;
    @(negedge clk); start_valid = 0; abort = 0; #1;
    n_checks++;
    if (busy !== 1'b1 || wr_addr_valid !== 1'b1 || wr_addr !== 10'd7) begin
      n_errors++; $display("FAIL abort_idle_start got busy=%b wv=%b wa=%0d exp 1 1 7",
                           busy, wr_addr_valid, wr_addr);
    end
    abort = 1;
    @(negedge clk); abort = 0; #1;
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_cleanup got busy=%b exp 0", busy); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk); start_valid = 1; start_base = 10'd50;
    @(negedge clk); start_valid = 0; wr_addr_ready = 1; rd_addr_ready = 1; bwd_go = 1;
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (rd_addr_valid !== 1'b1 || rd_addr !== 10'd52) begin
      n_errors++; $display("FAIL rst_pre_read got rv=%b ra=%0d exp 1 52", rd_addr_valid, rd_addr);
    end
    rst_n = 0; #1;
    n_checks++;
    if (busy !== 0 || rd_addr_valid !== 0 || rd_addr !== 0 || rd_layer !== 0 || done !== 0) begin
      n_errors++; $display("FAIL rst_mid_read got busy=%b rv=%b ra=%0d rl=%0d done=%b exp 0",
                           busy, rd_addr_valid, rd_addr, rd_layer, done);
    end
    @(negedge clk); rst_n = 1; wr_addr_ready = 0; rd_addr_ready = 0; bwd_go = 0;
    @(negedge clk); #1;
    n_checks++;
    if (start_ready !== 1'b1 || done !== 1'b0) begin
      n_errors++; $display("FAIL rst_release got sr=%b done=%b exp 1 0", start_ready, done);
    end
    run_pass(10'($urandom), 20, 0, "after_reset");
  endtask

  task automatic test_layer_one();
    logic [9:0] b;
    b = 10'($urandom);
    @(negedge clk); d1_start_valid = 1; d1_start_base = b;
    @(negedge clk); d1_start_valid = 0; #1;
    n_checks++;
    if (d1_wr_valid !== 1 || d1_wr_addr !== b) begin
      n_errors++; $display("FAIL l1_wr0 got v=%b a=%0d exp 1 %0d", d1_wr_valid, d1_wr_addr, b);
    end
    @(negedge clk); #1;
    n_checks++;
    if (d1_wr_valid !== 1 || d1_wr_addr !== b + 10'd1) begin
      n_errors++; $display("FAIL l1_wr1 got v=%b a=%0d exp 1 %0d", d1_wr_valid, d1_wr_addr,
                           b + 10'd1);
    end
    @(negedge clk); #1;
    n_checks++;
    if (d1_rd_valid !== 1 || d1_rd_addr !== b || d1_rd_layer !== 1'b0 || d1_wr_valid !== 0) begin
      n_errors++; $display("FAIL l1_rd got v=%b a=%0d l=%0d exp 1 %0d 0", d1_rd_valid, d1_rd_addr,
                           d1_rd_layer, b);
    end
    @(negedge clk); #1;
    n_checks++;
    if (d1_done !== 1 || d1_busy !== 0) begin
      n_errors++; $display("FAIL l1_done got done=%b busy=%b exp 1 0", d1_done, d1_busy);
    end
    @(negedge clk); #1;
    n_checks++;
    if (d1_done !== 0) begin n_errors++; $display("FAIL l1_done_pulse got %b exp 0", d1_done); end
  endtask

  initial begin
    test_reset();
    run_pass(10'd0, 0, 0, "basic");
    run_pass(10'd1022, 0, 0, "wrap");
    for (int k = 0; k < 4; k++) run_pass(10'($urandom), 40, 0, "stall");
    run_pass(10'd1022, 50, 1, "wrap_stall");
    run_pass(10'd300, 30, 2, "wait_bwd");
    test_abort();
    test_reset_mid_read();
    test_layer_one();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got stuck exp finish");
    $fatal(1);
  end

endmodule

// File: doc/stack_address_sequencer.md
STACK_ADDRESS_SEQUENCER -- requirements
Module: stack_address_sequencer

Interface
REQ-001 The block SHALL have parameter LAYER_MAX, default 3, number of weight matrices; LAYER_MAX+1 activations are stored per pass; legal range 1..2^STACK_ADDR_WIDTH-2.
REQ-002 The block SHALL have parameter STACK_ADDR_WIDTH, default 10, width of all stack addresses.
REQ-003 The block SHALL have clock and reset as decided: one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have ports start_valid (input, 1), start_ready (output, 1) and start_base (input, STACK_ADDR_WIDTH); together they request a pass rooted at stack address start_base.
REQ-007 The block SHALL have ports wr_addr (output, STACK_ADDR_WIDTH), wr_addr_valid (output, 1) and wr_addr_ready (input, 1); they form the write-address stream to the activation stack.
REQ-008 The block SHALL have port bwd_go, input, 1, level; while high, the backward pass is permitted to read.
REQ-009 The block SHALL have ports rd_addr (output, STACK_ADDR_WIDTH), rd_addr_valid (output, 1) and rd_addr_ready (input, 1); they form the paired-read address stream to the stack.
REQ-010 The block SHALL have port rd_layer, output, log2(LAYER_MAX)+1 bits, the layer index of the current read.
REQ-011 The block SHALL have port abort, input, 1, synchronous cancel of the current pass.
REQ-012 The block SHALL have ports busy (output, 1) and done (output, 1); done is a one-cycle end-of-pass pulse.

Function
REQ-013 The block SHALL implement states IDLE, WRITE, WAIT_BWD and READ.
REQ-014 In IDLE, start_ready SHALL be 1; on start_valid&&start_ready it SHALL latch base<=start_base, set wr_cnt<=0 and enter WRITE the next cycle.
REQ-015 In WRITE, the block SHALL hold wr_addr_valid=1 and wr_addr=(base+wr_cnt) mod 2^STACK_ADDR_WIDTH.
REQ-016 Each cycle with wr_addr_valid&&wr_addr_ready, wr_cnt SHALL increment; wr_addr SHALL be stable while ready is 0.
REQ-017 The beat accepted with wr_cnt==LAYER_MAX SHALL be the last write, so exactly LAYER_MAX+1 writes occur per pass; the state SHALL then go to WAIT_BWD, or directly to READ if bwd_go is 1 that cycle.
REQ-018 In WAIT_BWD, both valids SHALL be 0; the block SHALL enter READ the cycle after bwd_go is sampled 1, with rd_cnt<=LAYER_MAX-1.
REQ-019 In READ, rd_addr_valid SHALL equal bwd_go, rd_addr SHALL equal (base+rd_cnt) mod 2^STACK_ADDR_WIDTH, and rd_layer SHALL equal rd_cnt.
REQ-020 Dropping bwd_go in READ SHALL deassert rd_addr_valid the same cycle without changing rd_cnt.
REQ-021 On each accepted read beat, rd_cnt SHALL decrement, giving the order LAYER_MAX-1 down to 0; the stack returns pair (addr, addr+1).
REQ-022 The accepted read with rd_cnt==0 SHALL cause busy to drop and done=1 for exactly one cycle, with a return to IDLE.
REQ-023 start_ready SHALL be 0 outside IDLE; start requests outside IDLE are not consumed, and a new pass may start the cycle after done.
REQ-024 busy SHALL be 1 in WRITE, WAIT_BWD and READ, and 0 in IDLE.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with valids 0 that next cycle and no done pulse; abort SHALL have priority over a simultaneous handshake, and that beat is discarded (counter unchanged).
REQ-026 abort in IDLE SHALL be ignored; if abort and start_valid are both 1 in IDLE, the start SHALL be accepted.
REQ-027 Address arithmetic SHALL wrap modulo 2^STACK_ADDR_WIDTH.
REQ-028 All outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational ready-to-valid path, except that rd_addr_valid gates directly on bwd_go.

Reset
REQ-029 With rst_n=0, the state SHALL be IDLE and wr_addr_valid=0, rd_addr_valid=0, wr_addr=0, rd_addr=0, rd_layer=0, busy=0, done=0 and base=0, asynchronously.
REQ-030 Reset SHALL apply mid-pass with no done pulse; after release, start_ready=1 on the first clock.

Verification
REQ-031 LAYER_MAX=3, base=0, ready tied 1, bwd_go=1 -> wr_addr 0,1,2,3 on consecutive cycles, then rd_addr 2,1,0 with rd_layer 2,1,0, then one done pulse.
REQ-032 Random wr_addr_ready/rd_addr_ready stalls -> addresses held stable while stalled; exactly 4 writes and 3 reads occur.
REQ-033 base=1022, STACK_ADDR_WIDTH=10 -> writes to 1022,1023,0,1; reads at 0,1023,1022.
REQ-034 bwd_go=0 after the last write, raised 10 cycles later -> the block sits in WAIT_BWD with both valids 0, then reads start; bwd_go toggling mid-READ pauses rd_addr_valid with no skipped addresses.
REQ-035 abort asserted during the 2nd write handshake, and separately rst_n pulsed low during READ -> IDLE, no done, start_ready=1; the next pass is complete and correct.
REQ-036 LAYER_MAX=1 -> two writes (base, base+1), one read (base, rd_layer=0), then done.
